// File: rtl/sram_rmw_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the SRAM read-modify-write controller:
//   - WORD_SIZE default (data word width in bits) when not set externally
//   - state_t      : controller FSM state encoding
//   - merge_bytes  : pure byte-lane merge (old word, new word, be -> merged)
// ---------------------------------------------------------------------------
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package sram_ctrl_pkg;

    localparam int WORD_W = `WORD_SIZE;
    localparam int BE_W   = `WORD_SIZE / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_MERGE = 2'd2,
        RESP      = 2'd3
    } state_t;

    // Lane n of the result comes from new_word when be[n] is set, else from old_word.
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] merged;
        merged = {WORD_W{1'b0}};
        for (int n = 0; n < BE_W; n++) begin
            if (be[n]) begin
                merged[8*n +: 8] = new_word[8*n +: 8];
            end else begin
                merged[8*n +: 8] = old_word[8*n +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_rmw_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_rmw_ctrl_if
// Request/response bus of the SRAM read-modify-write controller.
//   req_valid/req_ready : request handshake
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address (bits [1:0] ignored)
//   req_wdata/req_be    : store data and byte-lane enables
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data (0 for stores)
// master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface sram_rmw_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int l2_num_words = 12
) ();

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [l2_num_words+1:0] req_addr;
    logic [WORD_W-1:0]       req_wdata;
    logic [BE_W-1:0]         req_be;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [WORD_W-1:0]       rsp_rdata;

    modport master (
        output req_valid,
        input  req_ready,
        output req_write,
        output req_addr,
        output req_wdata,
        output req_be,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        input  req_be,
        output rsp_valid,
        input  rsp_ready,
        output rsp_rdata
    );

endinterface

// File: rtl/sram_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// sram_rmw_ctrl
// Single-outstanding load/store controller placed beside an SRAM with a
// registered one-cycle read port (B) and a write port. Partial stores are
// done as read-modify-write; full-word and empty-mask stores skip the read.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_req_valid/o_req_ready           request handshake
//   i_req_write, i_req_addr           op (1 = store) and byte address
//   i_req_wdata, i_req_be             store data and byte-lane enables
//   o_rsp_valid/i_rsp_ready           response handshake
//   o_rsp_rdata                       load data, 0 for stores
//   o_sram_re/o_sram_raddr/i_sram_rdata   SRAM read port
//   o_sram_we/o_sram_waddr/o_sram_wdata   SRAM write port
// ---------------------------------------------------------------------------
module sram_rmw_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int num_words    = 4096,
    parameter int l2_num_words = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst,

    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_write,
    input  logic [l2_num_words+1:0] i_req_addr,
    input  logic [WORD_W-1:0]       i_req_wdata,
    input  logic [BE_W-1:0]         i_req_be,

    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [WORD_W-1:0]       o_rsp_rdata,

    output logic                    o_sram_re,
    output logic [l2_num_words-1:0] o_sram_raddr,
    input  logic [WORD_W-1:0]       i_sram_rdata,

    output logic                    o_sram_we,
    output logic [l2_num_words-1:0] o_sram_waddr,
    output logic [WORD_W-1:0]       o_sram_wdata
);

    // The word address width must cover the array exactly.
    if (num_words != (1 << l2_num_words)) begin : g_bad_geometry
        $error("sram_rmw_ctrl: num_words must equal 2**l2_num_words");
    end

    state_t                  state_r;
    state_t                  next_state_s;
    logic [l2_num_words-1:0] addr_r;
    logic [WORD_W-1:0]       wdata_r;
    logic [BE_W-1:0]         be_r;
    logic [WORD_W-1:0]       rsp_rdata_r;

    logic [l2_num_words-1:0] req_word_s;
    logic                    accept_s;
    logic                    be_full_s;
    logic                    be_none_s;
    logic                    re_s;
    logic [l2_num_words-1:0] raddr_s;
    logic                    we_s;
    logic [l2_num_words-1:0] waddr_s;
    logic [WORD_W-1:0]       wdata_s;
    logic                    unused_addr_bits_s;

    // Byte-offset bits carry no meaning for a word-wide SRAM.
    assign unused_addr_bits_s = ^i_req_addr[1:0];
    assign req_word_s         = i_req_addr[l2_num_words+1:2];
    assign be_full_s          = (i_req_be == {BE_W{1'b1}});
    assign be_none_s          = (i_req_be == {BE_W{1'b0}});

    // Ready only in IDLE and never while reset is held.
    assign o_req_ready = (state_r == IDLE) && !i_rst;
    assign accept_s    = i_req_valid && o_req_ready;

    // Next-state and SRAM port decode; all strobes default low, addresses/data to 0.
    always_comb begin
        next_state_s = state_r;
        re_s         = 1'b0;
        raddr_s      = {l2_num_words{1'b0}};
        we_s         = 1'b0;
        waddr_s      = {l2_num_words{1'b0}};
        wdata_s      = {WORD_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (!i_req_write) begin
                        re_s         = 1'b1;
                        raddr_s      = req_word_s;
                        next_state_s = LOAD_WAIT;
                    end else if (be_full_s) begin
                        we_s         = 1'b1;
                        waddr_s      = req_word_s;
                        wdata_s      = i_req_wdata;
                        next_state_s = RESP;
                    end else if (be_none_s) begin
                        next_state_s = RESP;
                    end else begin
                        // Partial store: fetch the old word now, write the merge next cycle.
                        re_s         = 1'b1;
                        raddr_s      = req_word_s;
                        next_state_s = RMW_MERGE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD_WAIT: begin
                next_state_s = RESP;
            end
            RMW_MERGE: begin
                we_s         = 1'b1;
                waddr_s      = addr_r;
                wdata_s      = merge_bytes(i_sram_rdata, wdata_r, be_r);
                next_state_s = RESP;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Reset gating: a merge write caught by reset must not reach the array.
    assign o_sram_re    = re_s && !i_rst;
    assign o_sram_raddr = o_sram_re ? raddr_s : {l2_num_words{1'b0}};
    assign o_sram_we    = we_s && !i_rst;
    assign o_sram_waddr = o_sram_we ? waddr_s : {l2_num_words{1'b0}};
    assign o_sram_wdata = o_sram_we ? wdata_s : {WORD_W{1'b0}};

    assign o_rsp_valid  = (state_r == RESP) && !i_rst;
    assign o_rsp_rdata  = i_rst ? {WORD_W{1'b0}} : rsp_rdata_r;

    // State register and request capture; request fields are only sampled on accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= IDLE;
            addr_r      <= {l2_num_words{1'b0}};
            wdata_r     <= {WORD_W{1'b0}};
            be_r        <= {BE_W{1'b0}};
            rsp_rdata_r <= {WORD_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                addr_r      <= req_word_s;
                wdata_r     <= i_req_wdata;
                be_r        <= i_req_be;
                rsp_rdata_r <= {WORD_W{1'b0}};
            end else if (state_r == LOAD_WAIT) begin
                rsp_rdata_r <= i_sram_rdata;
            end
        end
    end

endmodule
